// File: rtl/regression_pkg.sv
// regression_pkg: shared widths, nibble codes, FSM states and digit record for the result transmitter.
package regression_pkg;
    localparam int RESULT_WIDTH = 14;
    localparam int FRAME_LEN = 12;
    localparam logic [3:0] HDR = 4'hA;
    localparam logic [3:0] EOF = 4'hE;
    localparam logic [3:0] NEG = 4'hF;
    localparam logic [3:0] POS = 4'h0;
    typedef enum logic [1:0] {IDLE, CONVERT, SEND} tx_state_t;
    typedef struct packed {
        logic       sign;
        logic       sat;
        logic [3:0] tens;
        logic [3:0] ones;
    } digit_t;
endpackage

// File: rtl/tx_digit_conv.sv
// tx_digit_conv: signed value to sign/tens/ones digits, saturating at 99.
module tx_digit_conv
    import regression_pkg::*;
#(
    parameter int W = RESULT_WIDTH
) (
    input  logic [W-1:0] i_value,
    output digit_t       o_digit
);
    logic [W:0] w_ext;
    logic [W:0] w_abs;
    logic       w_sat;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    // one extra bit so the most-negative input still has a representable magnitude
    always_comb begin
        w_ext  = {i_value[W-1], i_value};
        w_abs  = i_value[W-1] ? -w_ext : w_ext;
        w_sat  = w_abs > (W+1)'(99);
        w_tens = 4'(w_abs[6:0] / 7'd10);
        w_ones = 4'(w_abs[6:0] % 7'd10);
        o_digit.sign = i_value[W-1];
        o_digit.sat  = w_sat;
        o_digit.tens = w_sat ? 4'd9 : w_tens;
        o_digit.ones = w_sat ? 4'd9 : w_ones;
    end
endmodule

// File: rtl/regression_result_tx.sv
// regression_result_tx: captures regression results on start and streams them as a 12-nibble
// decimal frame over a valid/ready handshake.
module regression_result_tx
    import regression_pkg::*;
#(
    parameter int RESULT_WIDTH = regression_pkg::RESULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [RESULT_WIDTH-1:0] slope_in,
    input  logic [RESULT_WIDTH-1:0] intercept_in,
    input  logic [RESULT_WIDTH-1:0] det_in,
    input  logic                    err_det,
    input  logic                    err_values,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [3:0]              tx_data,
    output logic                    tx_last,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);
    localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

    tx_state_t               r_state;
    tx_state_t               w_next;
    logic [3:0]              r_idx;
    logic [RESULT_WIDTH-1:0] r_slope;
    logic [RESULT_WIDTH-1:0] r_icpt;
    logic [RESULT_WIDTH-1:0] r_det;
    logic                    r_err_det;
    logic                    r_err_values;
    digit_t                  r_dig_s;
    digit_t                  r_dig_i;
    digit_t                  r_dig_d;
    digit_t                  w_dig_s;
    digit_t                  w_dig_i;
    digit_t                  w_dig_d;
    logic                    r_frame_done;
    logic                    r_overrun;
    logic                    w_accept;
    logic                    w_eof_acc;
    logic [3:0]              w_status;

    tx_digit_conv #(.W(RESULT_WIDTH)) u_conv_s (.i_value(r_slope), .o_digit(w_dig_s));
    tx_digit_conv #(.W(RESULT_WIDTH)) u_conv_i (.i_value(r_icpt),  .o_digit(w_dig_i));
    tx_digit_conv #(.W(RESULT_WIDTH)) u_conv_d (.i_value(r_det),   .o_digit(w_dig_d));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_accept  = r_state == IDLE && start;
        w_eof_acc = r_state == SEND && tx_ready && r_idx == LAST;
        w_next    = r_state == IDLE    ? (start ? CONVERT : IDLE) :
                    r_state == CONVERT ? SEND :
                    (w_eof_acc ? IDLE : SEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx        <= '0;
            r_slope      <= '0;
            r_icpt       <= '0;
            r_det        <= '0;
            r_err_det    <= 1'b0;
            r_err_values <= 1'b0;
            r_dig_s      <= '0;
            r_dig_i      <= '0;
            r_dig_d      <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_slope      <= slope_in;
                r_icpt       <= intercept_in;
                r_det        <= det_in;
                r_err_det    <= err_det;
                r_err_values <= err_values;
            end
            if (r_state == CONVERT) begin
                r_dig_s <= w_dig_s;
                r_dig_i <= w_dig_i;
                r_dig_d <= w_dig_d;
            end
            if (r_state == SEND && tx_ready) r_idx <= r_idx == LAST ? 4'd0 : r_idx + 4'd1;
            r_frame_done <= w_eof_acc;
            // a start arriving while busy is dropped but remembered until the next accepted start
            if (w_accept)   r_overrun <= 1'b0;
            else if (start) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        w_status = {r_dig_s.sat | r_dig_i.sat | r_dig_d.sat, 1'b0, r_err_values, r_err_det};
        tx_valid = r_state == SEND;
        busy     = r_state != IDLE;
        tx_last  = tx_valid && r_idx == LAST;
        frame_done = r_frame_done;
        overrun  = r_overrun;
        tx_data  = 4'h0;
        if (tx_valid) begin
            case (r_idx)
                4'd0:    tx_data = HDR;
                4'd1:    tx_data = r_dig_s.sign ? NEG : POS;
                4'd2:    tx_data = r_dig_s.tens;
                4'd3:    tx_data = r_dig_s.ones;
                4'd4:    tx_data = r_dig_i.sign ? NEG : POS;
                4'd5:    tx_data = r_dig_i.tens;
                4'd6:    tx_data = r_dig_i.ones;
                4'd7:    tx_data = r_dig_d.sign ? NEG : POS;
                4'd8:    tx_data = r_dig_d.tens;
                4'd9:    tx_data = r_dig_d.ones;
                4'd10:   tx_data = w_status;
                default: tx_data = EOF;
            endcase
        end
    end
endmodule

// File: tb/tb_regression_result_tx.sv
// tb_regression_result_tx: directed frames with hand-computed nibbles, stalls, overrun and mid-frame reset.
module tb_regression_result_tx;
    typedef logic [3:0] frame_t [12];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [13:0] slope_in = '0;
    logic [13:0] intercept_in = '0;
    logic [13:0] det_in = '0;
    logic        err_det = 1'b0;
    logic        err_values = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [3:0]  tx_data;
    logic        tx_last;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    int          tests = 0;
    int          failed = 0;

    regression_result_tx dut (
        .clk(clk), .rst(rst), .start(start), .slope_in(slope_in),
        .intercept_in(intercept_in), .det_in(det_in), .err_det(err_det),
        .err_values(err_values), .tx_ready(tx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input frame_t f, input logic [13:0] s, input logic [13:0] i,
                             input logic [13:0] d, input logic ed, input logic ev,
                             input bit stall, input int ovr_at, input int abort_at);
        int  k = 0;
        int  cyc = 0;
        bit  pulsed = 0;
        @(negedge clk);
        slope_in = s; intercept_in = i; det_in = d; err_det = ed; err_values = ev;
        start = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("convert_valid", {3'b0, tx_valid}, 4'h0);
        chk("convert_busy", {3'b0, busy}, 4'h1);
        chk("start_clears_overrun", {3'b0, overrun}, 4'h0);
        @(negedge clk);
        chk("send_valid", {3'b0, tx_valid}, 4'h1);
        while (k < 12 && cyc < 200) begin
            tx_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            chk($sformatf("nibble%0d", k), tx_data, f[k]);
            chk($sformatf("last%0d", k), {3'b0, tx_last}, {3'b0, k == 11});
            chk($sformatf("valid%0d", k), {3'b0, tx_valid}, 4'h1);
            if (k == abort_at) begin
                chk("pre_reset_overrun", {3'b0, overrun}, 4'h1);
                rst = 1'b0;
                #1;
                chk("rst_valid", {3'b0, tx_valid}, 4'h0);
                chk("rst_busy", {3'b0, busy}, 4'h0);
                chk("rst_data", tx_data, 4'h0);
                chk("rst_overrun", {3'b0, overrun}, 4'h0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            start = (k == ovr_at && !pulsed);
            if (start) begin
                pulsed = 1;
                slope_in = 14'h1234; intercept_in = 14'h2AAA; det_in = 14'h0555;
            end
            @(negedge clk);
            start = 1'b0;
            if (tx_ready) k++;
            cyc++;
        end
        chk("frame_timeout", {3'b0, k == 12}, 4'h1);
        chk("end_valid", {3'b0, tx_valid}, 4'h0);
        chk("end_busy", {3'b0, busy}, 4'h0);
        chk("frame_done", {3'b0, frame_done}, 4'h1);
        @(negedge clk);
        chk("frame_done_pulse", {3'b0, frame_done}, 4'h0);
    endtask

    initial begin
        frame_t f1 = '{4'hA, 4'h0, 4'h1, 4'h2, 4'hF, 4'h0, 4'h7, 4'h0, 4'h5, 4'h4, 4'h0, 4'hE};
        frame_t f2 = '{4'hA, 4'hF, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h9, 4'h8, 4'hE};
        frame_t f3 = '{4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'hE};
        frame_t f4 = '{4'hA, 4'hF, 4'h9, 4'h9, 4'h0, 4'h4, 4'h5, 4'hF, 4'h9, 4'h9, 4'h8, 4'hE};
        @(negedge clk);
        chk("reset_valid", {3'b0, tx_valid}, 4'h0);
        chk("reset_busy", {3'b0, busy}, 4'h0);
        chk("reset_data", tx_data, 4'h0);
        chk("reset_last", {3'b0, tx_last}, 4'h0);
        chk("reset_done", {3'b0, frame_done}, 4'h0);
        chk("reset_overrun", {3'b0, overrun}, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(f1, 14'd12, -14'sd7, 14'd54, 1'b0, 1'b0, 0, -1, -1);
        run_frame(f1, 14'd12, -14'sd7, 14'd54, 1'b0, 1'b0, 1, -1, -1);
        run_frame(f2, 14'h2000, 14'd0, 14'd150, 1'b0, 1'b0, 0, -1, -1);
        run_frame(f3, 14'd0, 14'd0, 14'd0, 1'b1, 1'b1, 0, -1, -1);
        run_frame(f4, -14'sd99, 14'd45, -14'sd100, 1'b0, 1'b0, 0, 5, -1);
        chk("overrun_sticky", {3'b0, overrun}, 4'h1);
        run_frame(f1, 14'd12, -14'sd7, 14'd54, 1'b0, 1'b0, 0, -1, -1);
        run_frame(f1, 14'd12, -14'sd7, 14'd54, 1'b0, 1'b0, 0, 3, 6);
        chk("post_reset_idle", {3'b0, busy}, 4'h0);
        run_frame(f1, 14'd12, -14'sd7, 14'd54, 1'b0, 1'b0, 0, -1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/regression_result_tx.md
Name: regression_result_tx

Overview:
- Transmit side of the regression datapath: the mirror of the sample-loading input path.
- On a completion pulse it captures slope, intercept, determinant and error flags.
- It converts each to sign/tens/ones decimal digits and streams them out as a fixed 12-nibble frame over a valid/ready handshake.
- Sits after the final multiply and inverse; feeds a display/UART nibble consumer.

Parameters:
- RESULT_WIDTH, 14, width of each signed two's-complement input value.
- FRAME_LEN, 12, nibbles per frame (fixed; must not be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle completion pulse (done of final multiply).
- slope_in  in  RESULT_WIDTH  signed slope (C10).
- intercept_in  in  RESULT_WIDTH  signed intercept (C00).
- det_in  in  RESULT_WIDTH  signed determinant.
- err_det  in  1  singular-matrix flag.
- err_values  in  1  input-matrix error flag.
- tx_ready  in  1  consumer accepts the current nibble.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  4  current nibble.
- tx_last  out  1  high with the final (EOF) nibble.
- busy  out  1  frame capture/conversion/transmission in progress.
- frame_done  out  1  one-cycle pulse after EOF is accepted.
- overrun  out  1  sticky: start arrived while busy.

Behaviour:
- Reset (rst=0, async) sets all outputs to 0, sets state to IDLE and clears the nibble index. Any partial frame is aborted and never resumed.
- FSM states:
  - IDLE: start=1 captures all inputs into registers at that edge, clears overrun, goes to CONVERT, busy=1.
  - CONVERT: exactly one cycle. The digit converter output is registered (sign, tens, ones, sat per field); go to SEND.
  - SEND: tx_valid=1. The nibble advances only on an edge where tx_valid && tx_ready. A new nibble is presented the next cycle (back-to-back, 1 nibble/cycle at full throughput).
  - When EOF is accepted: go to IDLE, tx_valid=0, busy=0, frame_done=1 for exactly the next cycle.
- Latency: start seen at edge E0 -> tx_valid=1 after E1 (2 cycles after start). With tx_ready held high, 12 more cycles to the EOF handshake.
- Handshake: while tx_valid && !tx_ready, tx_data and tx_last hold stable. tx_valid never drops mid-frame.
- Frame order (index 0..11):
  - 0: 0xA (header)
  - 1..3: slope sign, tens, ones
  - 4..6: intercept sign, tens, ones
  - 7..9: det sign, tens, ones
  - 10: status = {sat_any, 0, err_values, err_det}
  - 11: 0xE (EOF, tx_last=1)
- Sign nibble: 0xF if the value is negative, else 0x0.
- Digit rule: abs = magnitude computed in RESULT_WIDTH+1 bits, so the most-negative value is handled.
  - abs > 99: tens=9, ones=9, field sat=1.
  - Otherwise tens = abs/10, ones = abs%10.
  - sat_any = OR of the three field sat bits.
- start while busy (CONVERT or SEND, including the frame_done cycle only if state != IDLE): ignored, overrun=1 and held until the next accepted start.
- frame_done cycle is IDLE, so a start in that cycle is accepted.
- Simultaneous start and EOF handshake in SEND: start is ignored and sets overrun.

Decomposition:
- regression_pkg holds:
  - RESULT_WIDTH default and FRAME_LEN.
  - Nibble codes HDR=4'hA, EOF=4'hE, NEG=4'hF, POS=4'h0.
  - The tx_state_t enum {IDLE, CONVERT, SEND}.
  - A packed struct digit_t {sign, sat, tens[3:0], ones[3:0]}.
- One combinational sub-module, tx_digit_conv (signed value -> digit_t with saturation), instantiated three times.
- Frame mux and FSM stay in the top module.

Test Plan:
- slope=12, intercept=-7, det=54, errs=0, tx_ready=1 -> tx_valid rises 2 cycles after start; nibbles A,0,1,2,F,0,7,0,5,4,0,E on consecutive cycles; tx_last only on E; frame_done 1 cycle later.
- Same frame with tx_ready toggling 1,0,0,1,... -> identical nibble sequence; data stable during stalls; no nibble skipped or repeated.
- det=150, slope=-8192 (most negative), intercept=0 -> slope F,9,9; intercept 0,0,0; det 0,9,9; status 0x8.
- err_det=1, err_values=1, all values 0 -> status nibble 0x3, digits all 0, frame still sent complete.
- start pulsed during SEND index 5 -> frame unchanged, overrun=1; next start after frame_done accepted and clears overrun.
- rst driven low at index 6 -> tx_valid, busy, tx_data, overrun immediately 0; after release, start sends a fresh full frame from header 0xA.
